// File: rtl/led_driver_pkg.sv
// Shared definitions for the multi-digit LED scanner: blank segment pattern,
// slot-state enum and the active-low hex-to-7-segment table ({a,b,c,d,e,f,g}).
package led_driver_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic {
      ST_DEAD,
      ST_ON
   } slot_state_e;

   // Active-low segment pattern for one hex digit
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h01;
         4'h1: s = 7'h4F;
         4'h2: s = 7'h12;
         4'h3: s = 7'h06;
         4'h4: s = 7'h4C;
         4'h5: s = 7'h24;
         4'h6: s = 7'h20;
         4'h7: s = 7'h0F;
         4'h8: s = 7'h00;
         4'h9: s = 7'h04;
         4'hA: s = 7'h08;
         4'hB: s = 7'h60;
         4'hC: s = 7'h31;
         4'hD: s = 7'h42;
         4'hE: s = 7'h30;
         default: s = 7'h38;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decoder
   import led_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   // Pure table lookup, no state
   always_comb begin
      seg_n = hex_to_seg(nibble);
   end

endmodule

// File: rtl/multi_digit_led_driver.sv
// Multiplexed common-anode 7-segment scanner for NUM_DIGITS digits with
// dead-time blanking between digits and a load/shadow double buffer that is
// copied to the displayed set only at a frame boundary, so a frame never tears.
// Optional feature macro: LED_DIM_EN adds a 4-bit brightness port that gates
// the anode inside each ON phase (sampled at frame start).
module multi_digit_led_driver
   import led_driver_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 16,
   parameter int DEAD_CYCLES = 2
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef LED_DIM_EN
   input  logic [3:0]              brightness,
`endif
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_start
);

   localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SLOT_W:0]   DEAD_LIM  = (SLOT_W + 1)'(DEAD_CYCLES);

   logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
   logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
   logic                    pending_q, pending_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    frame_start_q, frame_start_d;
   logic                    boundary;
   logic                    lit;
   slot_state_e             slot_state;
   logic [3:0]              nib_arr [NUM_DIGITS];
   logic [3:0]              cur_nib;
   logic [6:0]              seg_dec;
`ifdef LED_DIM_EN
   logic [3:0]              bright_q, bright_d;
   logic [3:0]              dim_ofs;
`endif

   // First slot of digit NUM_DIGITS-1; the reset state lands here too,
   // which makes the first cycle after reset a frame boundary.
   assign boundary = (slot_cnt_q == '0) && (digit_idx_q == IDX_LAST);

   // Split the about-to-be-displayed data into per-digit nibbles
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib_arr[gi] = act_data_d[4*gi +: 4];
   end
   assign cur_nib = nib_arr[digit_idx_q];

   seg7_hex_decoder u_dec (
      .nibble (cur_nib),
      .seg_n  (seg_dec)
   );

   // Scan counters and shadow/active double buffer next state
   always_comb begin
      slot_cnt_d  = slot_cnt_q + 1'b1;
      digit_idx_d = digit_idx_q;
      if (slot_cnt_q == SLOT_LAST) begin
         slot_cnt_d  = '0;
         digit_idx_d = (digit_idx_q == '0) ? IDX_LAST : digit_idx_q - 1'b1;
      end
      sh_data_d   = sh_data_q;
      sh_dp_d     = sh_dp_q;
      sh_blank_d  = sh_blank_q;
      act_data_d  = act_data_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      pending_d   = pending_q;
      if (boundary) begin
         if (pending_q) begin
            act_data_d  = sh_data_q;
            act_dp_d    = sh_dp_q;
            act_blank_d = sh_blank_q;
         end
         pending_d = 1'b0;
      end
      // A load coinciding with the boundary only reaches the shadow and stays pending
      if (load) begin
         sh_data_d  = data_in;
         sh_dp_d    = dp_in;
         sh_blank_d = blank_in;
         pending_d  = 1'b1;
      end
   end

   // Pin values for the current counter state; they appear one cycle later
   always_comb begin
      slot_state    = ({1'b0, slot_cnt_q} < DEAD_LIM) ? ST_DEAD : ST_ON;
      lit           = (slot_state == ST_ON) && !act_blank_d[digit_idx_q];
`ifdef LED_DIM_EN
      bright_d      = boundary ? brightness : bright_q;
      dim_ofs       = 4'(32'(slot_cnt_q) - 32'(DEAD_CYCLES));
      lit           = lit && (dim_ofs <= bright_d);
`endif
      an_d          = '1;
      seg_d         = SEG_OFF;
      dp_d          = 1'b1;
      frame_start_d = boundary;
      if (lit) begin
         an_d[digit_idx_q] = 1'b0;
         seg_d             = seg_dec;
         dp_d              = ~act_dp_d[digit_idx_q];
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_cnt_q    <= '0;
         digit_idx_q   <= IDX_LAST;
         sh_data_q     <= '0;
         sh_dp_q       <= '0;
         sh_blank_q    <= '1;
         act_data_q    <= '0;
         act_dp_q      <= '0;
         act_blank_q   <= '1;
         pending_q     <= 1'b0;
         an_q          <= '1;
         seg_q         <= SEG_OFF;
         dp_q          <= 1'b1;
         frame_start_q <= 1'b0;
`ifdef LED_DIM_EN
         bright_q      <= 4'hF;
`endif
      end else begin
         slot_cnt_q    <= slot_cnt_d;
         digit_idx_q   <= digit_idx_d;
         sh_data_q     <= sh_data_d;
         sh_dp_q       <= sh_dp_d;
         sh_blank_q    <= sh_blank_d;
         act_data_q    <= act_data_d;
         act_dp_q      <= act_dp_d;
         act_blank_q   <= act_blank_d;
         pending_q     <= pending_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         frame_start_q <= frame_start_d;
`ifdef LED_DIM_EN
         bright_q      <= bright_d;
`endif
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = frame_start_q;

endmodule
